// File: rtl/fma_rr_scheduler_if.sv
// +------------------------------------------------------------------+
// | fma_rr_scheduler_if : requester-side operation and response bus   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface fma_rr_scheduler_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*WIDTH-1:0] req_c;
  logic [NREQ*2-1:0]     req_rnd;
  logic                  resp_valid;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_result;

  modport master (
    output req_valid, req_a, req_b, req_c, req_rnd,
    input  req_ready, resp_valid, resp_id, resp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_rnd,
    output req_ready, resp_valid, resp_id, resp_result
  );
endinterface

`default_nettype wire

// File: rtl/fma_rr_scheduler.sv
// +------------------------------------------------------------------+
// | fma_rr_scheduler : round-robin sharing of one pipelined fpfma     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module fma_rr_scheduler #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int FMA_LAT = 3
) (
  input  wire logic                             clk,
  input  wire logic                             rst_n,
  input  wire logic                             en,
  fma_rr_scheduler_if.slave                     bus,
  output logic [WIDTH-1:0]                      fma_a,
  output logic [WIDTH-1:0]                      fma_b,
  output logic [WIDTH-1:0]                      fma_c,
  output logic [1:0]                            fma_rnd,
  input  wire logic [WIDTH-1:0]                 fma_result,
  output logic [$clog2(FMA_LAT+2):0]            inflight,
  output logic                                  idle
);

  localparam int CNTW = $clog2(FMA_LAT + 2) + 1;

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_found;
  logic             accept;
  logic             emit;

  logic [WIDTH-1:0] fma_a_q, fma_b_q, fma_c_q;
  logic [1:0]       fma_rnd_q;

  // Stage FMA_LAT lines up with fma_result holding the matching op's result
  logic             tag_v_q  [0:FMA_LAT];
  logic [IDW-1:0]   tag_id_q [0:FMA_LAT];

  logic             resp_valid_q;
  logic [IDW-1:0]   resp_id_q;
  logic [WIDTH-1:0] resp_result_q;
  logic [CNTW-1:0]  inflight_q, inflight_d;

  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!gnt_found && bus.req_valid[IDW'(idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  assign accept        = en && gnt_found;
  assign bus.req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;
  assign ptr_d         = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  assign emit       = tag_v_q[FMA_LAT];
  assign inflight_d = inflight_q + CNTW'(accept) - CNTW'(emit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      fma_a_q       <= '0;
      fma_b_q       <= '0;
      fma_c_q       <= '0;
      fma_rnd_q     <= 2'b00;
      for (int s = 0; s <= FMA_LAT; s++) begin
        tag_v_q[s]  <= 1'b0;
        tag_id_q[s] <= '0;
      end
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      inflight_q    <= '0;
    end else begin
      if (accept) begin
        fma_a_q     <= bus.req_a[gnt_idx*WIDTH +: WIDTH];
        fma_b_q     <= bus.req_b[gnt_idx*WIDTH +: WIDTH];
        fma_c_q     <= bus.req_c[gnt_idx*WIDTH +: WIDTH];
        fma_rnd_q   <= bus.req_rnd[gnt_idx*2 +: 2];
        ptr_q       <= ptr_d;
        tag_id_q[0] <= gnt_idx;
      end
      tag_v_q[0] <= accept;
      for (int s = 1; s <= FMA_LAT; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end
      resp_valid_q <= emit;
      if (emit) begin
        resp_id_q     <= tag_id_q[FMA_LAT];
        resp_result_q <= fma_result;
      end
      inflight_q <= inflight_d;
    end
  end

  assign fma_a           = fma_a_q;
  assign fma_b           = fma_b_q;
  assign fma_c           = fma_c_q;
  assign fma_rnd         = fma_rnd_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;
  assign inflight        = inflight_q;
  assign idle            = (inflight_q == '0) && !accept;

endmodule

`default_nettype wire

// File: tb/tb_fma_rr_scheduler.sv
// +------------------------------------------------------------------+
// | tb_fma_rr_scheduler : randomized bench with a due-time queue model|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_fma_rr_scheduler;
  localparam int WIDTH   = 32;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int FMA_LAT = 3;
  localparam int CNTW    = $clog2(FMA_LAT + 2) + 1;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             en    = 1'b0;
  logic [WIDTH-1:0] fma_a, fma_b, fma_c, fma_result;
  logic [1:0]       fma_rnd;
  logic [CNTW-1:0]  inflight;
  logic             idle;

  fma_rr_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  fma_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .FMA_LAT(FMA_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .bus        (bus),
    .fma_a      (fma_a),
    .fma_b      (fma_b),
    .fma_c      (fma_c),
    .fma_rnd    (fma_rnd),
    .fma_result (fma_result),
    .inflight   (inflight),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  // Single-precision helpers via double: exact for the small integers used here
  function automatic logic [63:0] s2d(input logic [31:0] s);
    if (s[30:0] == 31'd0) return {s[31], 63'd0};
    return {s[31], 11'({3'b000, s[30:23]} + 11'd896), s[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2s(input logic [63:0] d);
    logic [10:0] e;
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] i2f(input int n);
    real r;
    r = n;
    return d2s($realtobits(r));
  endfunction

  function automatic logic [31:0] fma_ref(input logic [31:0] a, b, c);
    real r;
    r = $bitstoreal(s2d(a)) * $bitstoreal(s2d(b)) + $bitstoreal(s2d(c));
    return d2s($realtobits(r));
  endfunction

  // Behavioural fpfma: FMA_LAT clock edges from operands to result
  logic [WIDTH-1:0] fpipe [FMA_LAT];
  always @(posedge clk) begin
    fpipe[0] <= fma_ref(fma_a, fma_b, fma_c);
    for (int i = 1; i < FMA_LAT; i++) fpipe[i] <= fpipe[i-1];
  end
  assign fma_result = fpipe[FMA_LAT-1];

  typedef struct {
    int               due;
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] res;
  } exp_t;

  exp_t             mq[$];
  int               m_ptr  = 0;
  int               ecount = 0;
  logic             m_rv   = 1'b0;
  logic [IDW-1:0]   m_rid  = '0;
  logic [WIDTH-1:0] m_rres = '0;
  int               total  = 0;
  int               bad    = 0;

  logic [WIDTH-1:0] opa [NREQ];
  logic [WIDTH-1:0] opb [NREQ];
  logic [WIDTH-1:0] opc [NREQ];
  logic [1:0]       oprnd [NREQ];

  task automatic apply_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*WIDTH +: WIDTH] = opa[i];
      bus.req_b[i*WIDTH +: WIDTH] = opb[i];
      bus.req_c[i*WIDTH +: WIDTH] = opc[i];
      bus.req_rnd[i*2 +: 2]       = oprnd[i];
    end
  endtask

  task automatic set_rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      opa[i]   = i2f(int'($urandom_range(0, 100)));
      opb[i]   = i2f(int'($urandom_range(0, 100)));
      opc[i]   = i2f(int'($urandom_range(0, 100)));
      oprnd[i] = 2'($urandom_range(0, 3));
    end
    apply_ops();
  endtask

  // Expected grant: first valid requester at or above the pointer, wrapping
  task automatic model_grant(output int g);
    g = -1;
    if (en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (g < 0 && bus.req_valid[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
      end
    end
  endtask

  task automatic clock_edge(input int g);
    @(posedge clk);
    ecount++;
    if (g >= 0) begin
      mq.push_back('{ecount + FMA_LAT + 1, IDW'(g), fma_ref(opa[g], opb[g], opc[g])});
      m_ptr = (g + 1) % NREQ;
    end
    m_rv = 1'b0;
    if (mq.size() > 0 && mq[0].due == ecount) begin
      m_rv   = 1'b1;
      m_rid  = mq[0].id;
      m_rres = mq[0].res;
      void'(mq.pop_front());
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mq.delete();
    m_ptr  = 0;
    m_rv   = 1'b0;
    m_rid  = '0;
    m_rres = '0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    en = 1'b0;
    set_rand_ops();
    #1 rst_n = 1'b0;
    #2;
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    total++; if (bus.resp_id !== '0 || bus.resp_result !== '0) begin bad++; $display("FAIL reset_resp_data got id=%0d res=%h exp 0", bus.resp_id, bus.resp_result); end
    total++; if (inflight !== '0 || idle !== 1'b1) begin bad++; $display("FAIL reset_count got inflight=%0d idle=%b exp 0/1", inflight, idle); end
    total++; if ({fma_a, fma_b, fma_c, fma_rnd} !== '0) begin bad++; $display("FAIL reset_fma got a=%h b=%h c=%h rnd=%b exp 0", fma_a, fma_b, fma_c, fma_rnd); end
    total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int inf_exp [5] = '{1, 1, 1, 1, 0};
    do_reset();
    opa[2] = 32'h40400000; opb[2] = 32'h40000000; opc[2] = 32'h3F800000; oprnd[2] = 2'b01;
    apply_ops();
    bus.req_valid = 4'b0100;
    en = 1'b1;
    #1;
    total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", bus.req_ready); end
    clock_edge(2);
    bus.req_valid = '0;
    total++; if (fma_a !== 32'h40400000 || fma_rnd !== 2'b01) begin bad++; $display("FAIL single_fma got a=%h rnd=%b exp 40400000/01", fma_a, fma_rnd); end
    total++; if (inflight !== CNTW'(inf_exp[0])) begin bad++; $display("FAIL single_inflight0 got=%0d exp=%0d", inflight, inf_exp[0]); end
    for (int e = 1; e <= 4; e++) begin
      clock_edge(-1);
      total++;
      if (inflight !== CNTW'(inf_exp[e]) || bus.resp_valid !== (e == 4)) begin
        bad++; $display("FAIL single_edge%0d got inflight=%0d v=%b exp %0d/%b", e, inflight, bus.resp_valid, inf_exp[e], e == 4);
      end
    end
    total++;
    if (bus.resp_id !== 2'd2 || bus.resp_result !== 32'h40E00000) begin
      bad++; $display("FAIL single_result got id=%0d res=%h exp 2/40e00000", bus.resp_id, bus.resp_result);
    end
  endtask

  task automatic test_all_valid();
    int g;
    logic [NREQ-1:0] er;
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bus.req_valid = (c < 24) ? '1 : '0;
      set_rand_ops();
      #1; model_grant(g);
      er = (g >= 0) ? NREQ'(1) << g : '0;
      total++;
      if (bus.req_ready !== er || idle !== (mq.size() == 0 && g < 0) || (c < 24 && er !== NREQ'(1) << (c % NREQ))) begin
        bad++; $display("FAIL all_grant c=%0d got ready=%b idle=%b exp ready=%b", c, bus.req_ready, idle, er);
      end
      clock_edge(g);
      total++;
      if (bus.resp_valid !== m_rv || bus.resp_id !== m_rid || bus.resp_result !== m_rres || inflight !== CNTW'(mq.size())) begin
        bad++; $display("FAIL all_resp c=%0d got v=%b id=%0d res=%h inf=%0d exp v=%b id=%0d res=%h inf=%0d",
                        c, bus.resp_valid, bus.resp_id, bus.resp_result, inflight, m_rv, m_rid, m_rres, mq.size());
      end
    end
  endtask

  task automatic test_wrap();
    int g;
    int seq [4] = '{3, 1, 3, 1};
    logic [NREQ-1:0] er;
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 11; c++) begin
      bus.req_valid = (c == 0) ? 4'b0010 : (c <= 4) ? 4'b1010 : 4'b0000;
      set_rand_ops();
      #1; model_grant(g);
      er = (g >= 0) ? NREQ'(1) << g : '0;
      total++;
      if (bus.req_ready !== er || (c >= 1 && c <= 4 && bus.req_ready !== NREQ'(1) << seq[c-1])) begin
        bad++; $display("FAIL wrap_grant c=%0d got=%b exp=%b", c, bus.req_ready, er);
      end
      clock_edge(g);
      total++;
      if (bus.resp_valid !== m_rv || bus.resp_id !== m_rid || bus.resp_result !== m_rres || inflight !== CNTW'(mq.size())) begin
        bad++; $display("FAIL wrap_resp c=%0d got v=%b id=%0d res=%h inf=%0d exp v=%b id=%0d res=%h inf=%0d",
                        c, bus.resp_valid, bus.resp_id, bus.resp_result, inflight, m_rv, m_rid, m_rres, mq.size());
      end
    end
  endtask

  task automatic test_en_gap();
    int g;
    logic [NREQ-1:0] er;
    do_reset();
    bus.req_valid = '1;
    for (int c = 0; c < 16; c++) begin
      en = (c < 4 || c >= 9);
      if (c >= 11) bus.req_valid = '0;
      set_rand_ops();
      #1; model_grant(g);
      er = (g >= 0) ? NREQ'(1) << g : '0;
      total++;
      if (bus.req_ready !== er || idle !== (mq.size() == 0 && g < 0)) begin
        bad++; $display("FAIL engap_grant c=%0d got ready=%b idle=%b exp ready=%b", c, bus.req_ready, idle, er);
      end
      if (c == 8) begin
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL engap_idle got=%b exp=1", idle); end
      end
      if (c == 9) begin
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL engap_ptr got=%b exp=0001", bus.req_ready); end
      end
      clock_edge(g);
      total++;
      if (bus.resp_valid !== m_rv || bus.resp_id !== m_rid || bus.resp_result !== m_rres || inflight !== CNTW'(mq.size())) begin
        bad++; $display("FAIL engap_resp c=%0d got v=%b id=%0d res=%h inf=%0d exp v=%b id=%0d res=%h inf=%0d",
                        c, bus.resp_valid, bus.resp_id, bus.resp_result, inflight, m_rv, m_rid, m_rres, mq.size());
      end
    end
  endtask

  task automatic test_async_reset();
    int g;
    do_reset();
    en = 1'b1;
    bus.req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      set_rand_ops();
      #1; model_grant(g);
      clock_edge(g);
    end
    bus.req_valid = '0;
    total++; if (inflight !== CNTW'(3)) begin bad++; $display("FAIL areset_pre got inflight=%0d exp=3", inflight); end
    #2;
    rst_n = 1'b0;
    mq.delete();
    m_ptr = 0; m_rv = 1'b0; m_rid = '0; m_rres = '0;
    #1;
    total++;
    if (bus.resp_valid !== 1'b0 || inflight !== '0 || {fma_a, fma_b, fma_c, fma_rnd} !== '0) begin
      bad++; $display("FAIL areset_now got v=%b inf=%0d a=%h rnd=%b exp 0", bus.resp_valid, inflight, fma_a, fma_rnd);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1; model_grant(g);
      clock_edge(g);
      total++;
      if (bus.resp_valid !== 1'b0 || inflight !== '0) begin
        bad++; $display("FAIL areset_stale c=%0d got v=%b inf=%0d exp 0/0", c, bus.resp_valid, inflight);
      end
    end
    bus.req_valid = '1;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL areset_ptr got=%b exp=0001", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  task automatic test_drop();
    int g;
    logic [NREQ-1:0] er;
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.req_valid = (c == 0) ? 4'b0001 : (c == 1) ? 4'b1000 : 4'b0000;
      set_rand_ops();
      #1; model_grant(g);
      er = (g >= 0) ? NREQ'(1) << g : '0;
      total++;
      if (bus.req_ready !== er || (c == 1 && bus.req_ready !== 4'b1000)) begin
        bad++; $display("FAIL drop_grant c=%0d got=%b exp=%b", c, bus.req_ready, er);
      end
      clock_edge(g);
      total++;
      if (bus.resp_valid !== m_rv || bus.resp_id !== m_rid || bus.resp_result !== m_rres || inflight !== CNTW'(mq.size())) begin
        bad++; $display("FAIL drop_resp c=%0d got v=%b id=%0d res=%h inf=%0d exp v=%b id=%0d res=%h inf=%0d",
                        c, bus.resp_valid, bus.resp_id, bus.resp_result, inflight, m_rv, m_rid, m_rres, mq.size());
      end
    end
  endtask

  task automatic test_random();
    int g;
    logic [NREQ-1:0] er;
    do_reset();
    for (int c = 0; c < 310; c++) begin
      bus.req_valid = (c < 300) ? NREQ'($urandom) : '0;
      en = (c >= 300) || ($urandom_range(0, 4) != 0);
      set_rand_ops();
      #1; model_grant(g);
      er = (g >= 0) ? NREQ'(1) << g : '0;
      total++;
      if (bus.req_ready !== er || idle !== (mq.size() == 0 && g < 0)) begin
        bad++; $display("FAIL rand_grant c=%0d got ready=%b idle=%b exp ready=%b", c, bus.req_ready, idle, er);
      end
      clock_edge(g);
      total++;
      if (bus.resp_valid !== m_rv || bus.resp_id !== m_rid || bus.resp_result !== m_rres || inflight !== CNTW'(mq.size())) begin
        bad++; $display("FAIL rand_resp c=%0d got v=%b id=%0d res=%h inf=%0d exp v=%b id=%0d res=%h inf=%0d",
                        c, bus.resp_valid, bus.resp_id, bus.resp_result, inflight, m_rv, m_rid, m_rres, mq.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_wrap();
    test_en_gap();
    test_async_reset();
    test_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fma_rr_scheduler.md
Name: fma_rr_scheduler

Overview:
- Round-robin scheduler that shares one pipelined fpfma unit (A*B+C, 32-bit IEEE-754 single, 2-bit rnd) among NREQ requesters.
- Accepts one operation per cycle using valid/ready handshakes and registers the operands into fpfma.
- Tracks each in-flight operation's requester ID in a shift pipeline matched to the fpfma latency.
- Returns each result tagged with the ID of the requester that issued it.

Parameters:
- WIDTH, 32: operand/result width (single precision only).
- NREQ, 4: number of requesters (2..8).
- IDW, 2: requester ID width, equal to clog2(NREQ).
- FMA_LAT, 3: fpfma latency in clock edges from operand inputs to result. A value of 0 means fpfma is combinational.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  1 = grants allowed; 0 = no new grants, in-flight operations drain.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  one-hot grant (combinational).
- req_a, req_b, req_c  in  NREQ*WIDTH  operands. Requester i uses slice [i*WIDTH +: WIDTH].
- req_rnd  in  NREQ*2  rounding mode. Requester i uses slice [i*2 +: 2].
- fma_a, fma_b, fma_c  out  WIDTH  registered operands to fpfma A/B/C.
- fma_rnd  out  2  registered rounding mode to fpfma rnd.
- fma_result  in  WIDTH  fpfma result.
- resp_valid  out  1  registered response strobe.
- resp_id  out  IDW  requester ID of the response.
- resp_result  out  WIDTH  registered result.
- inflight  out  clog2(FMA_LAT+2)+1  count of accepted operations whose response has not yet been emitted.
- idle  out  1  1 when inflight==0 and no handshake is occurring this cycle.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - ptr=0.
  - fma_a/b/c=0, fma_rnd=2'b00.
  - Tag pipeline valid bits=0.
  - resp_valid=0, resp_id=0, resp_result=0.
  - inflight=0; idle=1.
  - Operations in flight when reset asserts are discarded and never reported.
- Arbitration (combinational):
  - If en=1 and any req_valid is set, grant the first set bit searching upward from ptr, wrapping modulo NREQ.
  - req_ready is one-hot on the granted bit and all zeros otherwise.
  - req_ready depends on req_valid. A requester must not make req_valid depend on req_ready.
- Accept edge k (valid&ready on index g):
  - fma_a/b/c/fma_rnd <= slices of index g.
  - ptr <= (g+1) mod NREQ.
  - Tag stage 0 <= {1, g}.
- Cycles with no grant:
  - ptr unchanged.
  - fma_* hold their values.
  - Tag stage 0 valid <= 0.
- Tag pipeline:
  - FMA_LAT+1 stages, each holding {valid, id}, shifting every cycle. There is no stall; fpfma is assumed non-stallable.
  - At edge k+FMA_LAT, fma_result holds the result of the op accepted at edge k.
- Response:
  - At edge k+FMA_LAT+1: resp_valid <= 1, resp_id <= g, resp_result <= fma_result.
  - Otherwise resp_valid <= 0; resp_id and resp_result hold their values.
  - Latency is FMA_LAT+1 edges from acceptance.
  - Throughput is 1 operation per cycle.
  - Responses are in order and have no backpressure; requesters must accept resp_valid in every cycle.
- inflight:
  - Increments on acceptance and decrements on response emission.
  - Simultaneous accept and response leaves it unchanged.
  - Maximum value is FMA_LAT+1.
- en behaviour:
  - Deasserting en mid-stream blocks new grants only.
  - Pipeline contents still drain and produce responses.
  - ptr is frozen while en=0.
- Wrap-around: after granting index NREQ-1, ptr=0.
- Fairness: a requester that is continuously valid is granted within NREQ cycles while en=1.

Test Plan:
- Single op, FMA_LAT=3: requester 2 presents A=0x40400000 (3.0), B=0x40000000 (2.0), C=0x3F800000 (1.0), rnd=01 at edge 0 -> req_ready=4'b0100 that cycle; resp_valid=1 with resp_id=2 and resp_result=0x40E00000 (7.0) exactly 4 edges later; inflight goes 1,1,1,1,0.
- All four requesters valid continuously with distinct operands, starting from ptr=0 -> grants in order 0,1,2,3,0,1...; one response per cycle after the first 4-edge latency; each resp_id matches its expected result.
- Fairness wrap: only requesters 1 and 3 valid and ptr=2 -> grants 3,1,3,1; ptr returns to 0 after each grant of 3.
- en=0 for 5 cycles mid-burst -> req_ready=0 for those cycles; the 4 in-flight responses still appear; idle=1 once drained; ptr is unchanged when en returns to 1.
- Reset asserted asynchronously between clock edges with 3 ops in flight -> resp_valid=0, inflight=0, ptr=0 and fma_*=0 immediately; no stale response appears after rst_n deasserts.
- A requester that drops req_valid in the same cycle another requester becomes valid -> the grant goes only to the requester that is valid; no grant or tag is recorded for an invalid requester.
